frame_pattern_generator: RTL and testbench
==========================================

Name: frame_pattern_generator

Overview:
- Parametrised, self-timed raster stimulus source for framebuffer bring-up and synthesis tests.
- Generates the periodic frame_start tick itself, then streams one full frame of pixels into the framebuffer over the pixel ready/accept handshake.
- Supports four selectable patterns: solid, colour bars, checkerboard and a moving box.
- Occupies the raster slot in front of the framebuffer, in place of a line generator fed by constant data.

Parameters:
- FRAME_PERIOD, 1666667: clk cycles between frame_start ticks (60 Hz at 100 MHz).
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines per frame.
- XW, 10: frame_x width.
- YW, 10: frame_y width.
- CW, 3: colour width.
- CHK_LOG2, 5: checker square size is 2^CHK_LOG2 pixels.
- BOX, 64: moving box edge length in pixels; BOX < WIDTH and BOX < HEIGHT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- en  in  1  tick generator enable
- mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box
- fg_color  in  CW  foreground colour
- bg_color  in  CW  background colour
- frame_ready  in  1  framebuffer accepts the presented pixel this cycle
- frame_start  out  1  one-cycle frame tick
- frame_rd_en  out  1  pixel valid
- frame_x  out  XW  pixel column
- frame_y  out  YW  pixel row
- px_color  out  CW  pixel colour
- raster_done  out  1  frame fully delivered
- frame_count  out  16  frames completed, wraps at 65535 -> 0
- overrun  out  1  sticky: tick arrived while DRAW

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all of the following clear to 0: period counter, frame_start, frame_rd_en, frame_x, frame_y, px_color, raster_done, frame_count, overrun, box_x, box_y, bar counters. Reset mid-frame abandons the frame immediately.
- Tick generator:
  - While en==1, the period counter counts 0..FRAME_PERIOD-1.
  - frame_start pulses high for one cycle when the counter wraps; first tick FRAME_PERIOD cycles after en rises.
  - en==0 holds the counter at 0, so no ticks; a frame in progress still completes.
- FSM states IDLE, DRAW, DONE:
  - IDLE/DONE + tick: go to DRAW. At the same edge, latch mode, fg_color and bg_color for the whole frame, set x=y=0, clear raster_done and advance the box.
  - DRAW: frame_rd_en=1 from the cycle after the tick (T+1). Outputs frame_x, frame_y and px_color are registered and held stable while frame_ready==0.
  - Accept = frame_rd_en && frame_ready. On accept, x increments; at x==WIDTH-1, x goes to 0 and y increments.
  - Accept of (WIDTH-1, HEIGHT-1): go to DONE with frame_rd_en=0, raster_done=1 and frame_count+1 at the next edge.
  - Full throughput is 1 pixel/cycle. With frame_ready held high, raster_done rises at T+WIDTH*HEIGHT+1.
  - Tick while DRAW: ignored (frame continues); overrun sets and stays 1 until reset.
  - DONE: raster_done stays 1 until the next tick.
- Patterns (colour computed for the coordinate being presented):
  - Mode 0: fg_color.
  - Mode 1: colour = bar index 0..7. Bar width is WIDTH/8 (integer); a bar counter steps every WIDTH/8 pixels and saturates at 7; it resets at each line start.
  - Mode 2: (x[CHK_LOG2] ^ y[CHK_LOG2]) ? fg_color : bg_color.
  - Mode 3: fg_color when box_x <= x < box_x+BOX and box_y <= y < box_y+BOX, else bg_color.
    - At each frame start, box_x increments by 1 and wraps to 0 after WIDTH-BOX.
    - box_y does the same independently, wrapping after HEIGHT-BOX.
    - The first frame after reset draws the box at (1,1).
- Widths: x/y compares are unsigned at XW/YW bits; frame_count is a 16-bit wrapping counter.

Test Plan:
- FRAME_PERIOD=100, WIDTH=8, HEIGHT=4, frame_ready=1, mode 0, fg=3'b101, en=1 -> ticks at cycles 100, 200…; 32 pixels at T+1..T+32, all px_color=5; raster_done rises at T+33; frame_count=1.
- Same setup, frame_ready toggling 1,0 -> each pixel held stable across stall cycles, no coordinate skipped or repeated; raster_done at T+64.
- WIDTH=16, mode 1 -> x=0,1 colour 0; x=2,3 colour 1; …; x=14,15 colour 7; bar counter restarts each line.
- CHK_LOG2=1, mode 2, fg=7, bg=0 -> row 0 colours 0,0,7,7,…; row 2 inverted.
- FRAME_PERIOD=20, WIDTH=8, HEIGHT=4, frame_ready=0 -> second tick during DRAW sets overrun=1, frame continues from its stall point.
- Mode 3 with WIDTH=HEIGHT=8, BOX=2:
  - Frame 1: box at (1,1).
  - Frame 7: box at (0,0) after wrap.
  - Reset asserted mid-frame: next cycle frame_rd_en=0, state IDLE, box restarts at (1,1).

Source files
------------

// File: rtl/frame_pattern_generator.sv
// frame_pattern_generator
// Self-timed raster stimulus source. It generates a periodic frame_start tick
// and then streams one full frame of pixels over a ready/accept handshake.
// The pattern can be a solid colour, colour bars, a checkerboard or a moving box.
// The mode and both colours are captured at frame start and stay fixed for the whole frame.

module frame_pattern_generator #(
    parameter int FRAME_PERIOD = 1666667,
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int XW           = 10,
    parameter int YW           = 10,
    parameter int CW           = 3,
    parameter int CHK_LOG2     = 5,
    parameter int BOX          = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] fg_color,
    input  logic [CW-1:0] bg_color,
    input  logic          frame_ready,
    output logic          frame_start,
    output logic          frame_rd_en,
    output logic [XW-1:0] frame_x,
    output logic [YW-1:0] frame_y,
    output logic [CW-1:0] px_color,
    output logic          raster_done,
    output logic [15:0]   frame_count,
    output logic          overrun
);

    localparam int PW  = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int BW  = ((WIDTH / 8) > 0) ? (WIDTH / 8) : 1;
    localparam int BCW = $clog2(BW + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   period_cnt_r;
    logic [1:0]      mode_r;
    logic [CW-1:0]   fg_r;
    logic [CW-1:0]   bg_r;
    logic [XW-1:0]   box_x_r;
    logic [YW-1:0]   box_y_r;
    logic [2:0]      bar_idx_r;
    logic [BCW-1:0]  bar_cnt_r;

    logic [XW-1:0]   nx_x_s;
    logic [YW-1:0]   nx_y_s;
    logic [2:0]      nx_bar_idx_s;
    logic [BCW-1:0]  nx_bar_cnt_s;
    logic [XW-1:0]   box_nx_x_s;
    logic [YW-1:0]   box_nx_y_s;
    logic            last_px_s;
    logic [CW-1:0]   tick_colour_s;
    logic [CW-1:0]   run_colour_s;

    // Colour of pixel (x, y) for a given pattern, using the frame's captured settings.
    function automatic logic [CW-1:0] pixel_colour(
        input logic [1:0]    m,
        input logic [CW-1:0] fg,
        input logic [CW-1:0] bg,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y,
        input logic [2:0]    bar,
        input logic [XW-1:0] bx,
        input logic [YW-1:0] by
    );
        logic          in_box;
        logic [CW-1:0] pc;
        // The upper box bound needs one extra bit, so it cannot overflow at the right and bottom edges.
        in_box = (x >= bx) && ({1'b0, x} < ({1'b0, bx} + (XW+1)'(BOX))) &&
                 (y >= by) && ({1'b0, y} < ({1'b0, by} + (YW+1)'(BOX)));
        case (m)
            2'd0:    pc = fg;
            2'd1:    pc = CW'(bar);
            2'd2:    pc = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? fg : bg;
            2'd3:    pc = in_box ? fg : bg;
            default: pc = bg;
        endcase
        return pc;
    endfunction

    // Next raster position, bar tracking and box position; both colour candidates.
    always_comb begin
        nx_x_s       = '0;
        nx_y_s       = frame_y;
        nx_bar_idx_s = 3'd0;
        nx_bar_cnt_s = '0;
        if (frame_x == XW'(WIDTH - 1)) begin
            nx_x_s = '0;
            nx_y_s = frame_y + YW'(1);
        end else begin
            nx_x_s = frame_x + XW'(1);
            if (bar_cnt_r == BCW'(BW - 1)) begin
                nx_bar_cnt_s = '0;
                nx_bar_idx_s = (bar_idx_r == 3'd7) ? 3'd7 : bar_idx_r + 3'd1;
            end else begin
                nx_bar_cnt_s = bar_cnt_r + BCW'(1);
                nx_bar_idx_s = bar_idx_r;
            end
        end
        last_px_s  = (frame_x == XW'(WIDTH - 1)) && (frame_y == YW'(HEIGHT - 1));
        box_nx_x_s = (box_x_r == XW'(WIDTH - BOX))  ? '0 : box_x_r + XW'(1);
        box_nx_y_s = (box_y_r == YW'(HEIGHT - BOX)) ? '0 : box_y_r + YW'(1);
        // The first pixel of a frame uses the live inputs, because they are captured on that same edge.
        tick_colour_s = pixel_colour(mode, fg_color, bg_color, '0, '0, 3'd0,
                                     box_nx_x_s, box_nx_y_s);
        run_colour_s  = pixel_colour(mode_r, fg_r, bg_r, nx_x_s, nx_y_s, nx_bar_idx_s,
                                     box_x_r, box_y_r);
    end

    // Frame period counter and one-cycle frame_start tick when it wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            period_cnt_r <= '0;
            frame_start  <= 1'b0;
        end else if (en) begin
            if (period_cnt_r == PW'(FRAME_PERIOD - 1)) begin
                period_cnt_r <= '0;
                frame_start  <= 1'b1;
            end else begin
                period_cnt_r <= period_cnt_r + PW'(1);
                frame_start  <= 1'b0;
            end
        end else begin
            period_cnt_r <= '0;
            frame_start  <= 1'b0;
        end
    end

    // Raster FSM: starts a frame on a tick, walks the frame on accepts, and flags completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'd0;
            fg_r        <= '0;
            bg_r        <= '0;
            box_x_r     <= '0;
            box_y_r     <= '0;
            bar_idx_r   <= 3'd0;
            bar_cnt_r   <= '0;
            frame_rd_en <= 1'b0;
            frame_x     <= '0;
            frame_y     <= '0;
            px_color    <= '0;
            raster_done <= 1'b0;
            frame_count <= 16'd0;
            overrun     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (frame_start) begin
                        state_r     <= ST_DRAW;
                        mode_r      <= mode;
                        fg_r        <= fg_color;
                        bg_r        <= bg_color;
                        box_x_r     <= box_nx_x_s;
                        box_y_r     <= box_nx_y_s;
                        bar_idx_r   <= 3'd0;
                        bar_cnt_r   <= '0;
                        frame_x     <= '0;
                        frame_y     <= '0;
                        px_color    <= tick_colour_s;
                        frame_rd_en <= 1'b1;
                        raster_done <= 1'b0;
                    end
                end
                ST_DRAW: begin
                    // A tick during a frame is dropped; the frame keeps going.
                    if (frame_start) begin
                        overrun <= 1'b1;
                    end
                    if (frame_rd_en && frame_ready) begin
                        if (last_px_s) begin
                            state_r     <= ST_DONE;
                            frame_rd_en <= 1'b0;
                            raster_done <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            frame_x   <= nx_x_s;
                            frame_y   <= nx_y_s;
                            bar_idx_r <= nx_bar_idx_s;
                            bar_cnt_r <= nx_bar_cnt_s;
                            px_color  <= run_colour_s;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    frame_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pattern_generator.sv
// Randomised scoreboard bench for frame_pattern_generator. A reference model
// produces each frame's expected pixels from the pattern rules. A monitor pops
// them as the DUT presents accepted pixels.

module tb_frame_pattern_generator;

    localparam int FP   = 100;
    localparam int W    = 16;
    localparam int H    = 4;
    localparam int XW   = 6;
    localparam int YW   = 4;
    localparam int CW   = 3;
    localparam int CHK  = 1;
    localparam int BOX  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [CW-1:0] fg_color;
    logic [CW-1:0] bg_color;
    logic          frame_ready;
    logic          frame_start;
    logic          frame_rd_en;
    logic [XW-1:0] frame_x;
    logic [YW-1:0] frame_y;
    logic [CW-1:0] px_color;
    logic          raster_done;
    logic [15:0]   frame_count;
    logic          overrun;

    frame_pattern_generator #(
        .FRAME_PERIOD(FP), .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW),
        .CW(CW), .CHK_LOG2(CHK), .BOX(BOX)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .fg_color(fg_color),
        .bg_color(bg_color), .frame_ready(frame_ready), .frame_start(frame_start),
        .frame_rd_en(frame_rd_en), .frame_x(frame_x), .frame_y(frame_y),
        .px_color(px_color), .raster_done(raster_done), .frame_count(frame_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int c; } px_t;
    px_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int        en_edges  = 0;
    bit        exp_start = 0;
    bit        drawing   = 0;
    bit        exp_done  = 0;
    bit        exp_ovr   = 0;
    logic [15:0] exp_cnt = 16'd0;
    int        left      = 0;
    int        bx        = 0;
    int        by        = 0;

    task automatic push_frame(input int m, input int fg, input int bg, input int bxx, input int byy);
        int bw;
        int c;
        bw = (W / 8 > 0) ? W / 8 : 1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (m)
                    0: c = fg;
                    1: begin c = x / bw; if (c > 7) c = 7; end
                    2: c = (((x >> CHK) & 1) ^ ((y >> CHK) & 1)) ? fg : bg;
                    default: c = (x >= bxx && x < bxx + BOX && y >= byy && y < byy + BOX) ? fg : bg;
                endcase
                exp_q.push_back('{x: x, y: y, c: c});
            end
        end
    endtask

    // Model: checks the control outputs every cycle, then advances by one clock edge.
    initial begin
        bit was_drawing;
        forever begin
            @(negedge clk);
            #1;
            chk("frame_start", 32'(frame_start), 32'(exp_start));
            chk("frame_rd_en", 32'(frame_rd_en), 32'(drawing));
            chk("raster_done", 32'(raster_done), 32'(exp_done));
            chk("frame_count", 32'(frame_count), 32'(exp_cnt));
            chk("overrun",     32'(overrun),     32'(exp_ovr));
            if (!rst) begin
                en_edges = 0; exp_start = 0; drawing = 0; exp_done = 0;
                exp_ovr = 0; exp_cnt = 16'd0; left = 0; bx = 0; by = 0;
                exp_q.delete();
            end else begin
                was_drawing = drawing;
                if (drawing && frame_ready) begin
                    left--;
                    if (left == 0) begin
                        drawing  = 0;
                        exp_done = 1;
                        exp_cnt  = exp_cnt + 16'd1;
                    end
                end
                if (exp_start) begin
                    if (was_drawing) begin
                        exp_ovr = 1;
                    end else begin
                        bx = (bx + 1) % (W - BOX + 1);
                        by = (by + 1) % (H - BOX + 1);
                        drawing  = 1;
                        exp_done = 0;
                        left     = W * H;
                        push_frame(int'(mode), int'(fg_color), int'(bg_color), bx, by);
                    end
                end
                if (en) begin
                    en_edges++;
                    exp_start = (en_edges % FP) == 0;
                end else begin
                    en_edges  = 0;
                    exp_start = 0;
                end
            end
        end
    end

    // Monitor: every accepted pixel must match the next expected one.
    initial begin
        px_t e;
        forever begin
            @(negedge clk);
            if (frame_rd_en === 1'b1 && frame_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("pixel_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_x", 32'(frame_x), 32'(e.x));
                    chk("pixel_y", 32'(frame_y), 32'(e.y));
                    chk("pixel_colour", 32'(px_color), 32'(e.c));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus
    initial begin
        rst = 1'b0; en = 1'b0; frame_ready = 1'b1;
        mode = 2'd0; fg_color = 3'b101; bg_color = 3'b010;
        step(3);
        rst = 1'b1; en = 1'b1;
        // Full throughput: solid, bars, checker
        step(210);
        mode = 2'd1;
        step(100);
        mode = 2'd2; fg_color = 3'd7; bg_color = 3'd0;
        step(100);
        // Alternating ready: a frame runs past the next tick
        for (int i = 0; i < 300; i++) begin
            frame_ready = (i % 2 == 0);
            if (i % 97 == 0) mode = 2'($urandom_range(0, 3));
            step(1);
        end
        frame_ready = 1'b1;
        // Tick generator paused
        en = 1'b0;
        step(150);
        en = 1'b1;
        // Random backpressure and settings
        for (int i = 0; i < 1500; i++) begin
            frame_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                mode     = 2'($urandom_range(0, 3));
                fg_color = 3'($urandom_range(0, 7));
                bg_color = 3'($urandom_range(0, 7));
            end
            step(1);
        end
        // Reset in the middle of a frame, then the moving box through its wraps
        frame_ready = 1'b1;
        for (int i = 0; i < 300 && frame_rd_en !== 1'b1; i++) step(1);
        chk("draw_before_reset", 32'(frame_rd_en), 32'd1);
        step(10);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        mode = 2'd3; fg_color = 3'd6; bg_color = 3'd1;
        step(1700);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
